// File: rtl/sprite_rom_if.sv
// Requester-side bus of the sprite ROM arbiter.
//   req      : level request per requester (bit 0 = pixel path)
//   req_addr : requester i's address in bits [i*ADDR_W +: ADDR_W]
//   gnt      : one-hot grant, combinational in the request cycle
//   rvalid   : one-hot read-data-valid, registered
//   rdata    : registered read data shared by all requesters
// master = requester side, slave = arbiter side.
interface sprite_rom_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]       rdata;

  modport master (output req, output req_addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input req_addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Shares one sprite ROM read port between N_REQ requesters.
// Requester 0 (pixel path) has strict priority during active video
// (blank=1); otherwise all requesters are served round-robin.
// Grant is combinational, read data returns two cycles after the grant.
//   vga_clk     : clock, all state on posedge (ROM runs on the negedge)
//   reset_n     : synchronous active-low reset
//   blank       : 1 = active video, 0 = blanking
//   bus         : requester bus (req/req_addr/gnt/rvalid/rdata)
//   rom_address : registered ROM address
//   rom_q       : ROM output, settled before the posedge after it samples
module sprite_rom_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic              blank,
  sprite_rom_if.slave       bus,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_q
);

  localparam int IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("sprite_rom_arbiter: N_REQ must be 2..8");
  end

  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  issue_id_q, issue_id_d;
  logic              issue_v_q, issue_v_d;
  logic [ADDR_W-1:0] rom_address_q, rom_address_d;
  logic [N_REQ-1:0]  rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              gnt_any;
  logic [IDX_W-1:0]  gnt_idx;
  logic [N_REQ-1:0]  gnt_vec;
  int                cand;
  logic [IDX_W-1:0]  cand_idx;

  // Arbitration
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    rr_ptr_d = rr_ptr_q;
    cand     = 0;
    cand_idx = '0;
    if (blank && bus.req[0]) begin
      // pixel path pre-empts; pointer is left alone so blanking resumes fairly
      gnt_any = 1'b1;
    end else begin
      // cyclic search starting just after the last round-robin winner
      for (int k = 1; k <= N_REQ; k++) begin
        cand = int'(rr_ptr_q) + k;
        if (cand >= N_REQ) cand = cand - N_REQ;
        cand_idx = cand[IDX_W-1:0];
        if (!gnt_any && bus.req[cand_idx]) begin
          gnt_any = 1'b1;
          gnt_idx = cand_idx;
        end
      end
      if (gnt_any) rr_ptr_d = gnt_idx;
    end
    if (!reset_n) begin
      gnt_any  = 1'b0;
      rr_ptr_d = rr_ptr_q;
    end
  end

  always_comb begin
    gnt_vec = '0;
    if (gnt_any) gnt_vec[gnt_idx] = 1'b1;
  end

  // Issue and return stages
  always_comb begin
    rom_address_d = rom_address_q;
    issue_id_d    = issue_id_q;
    issue_v_d     = gnt_any;
    if (gnt_any) begin
      rom_address_d = bus.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
      issue_id_d    = gnt_idx;
    end
    rvalid_d = '0;
    if (issue_v_q) rvalid_d[issue_id_q] = 1'b1;
    rdata_d = rom_q;
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      rr_ptr_q      <= IDX_W'(N_REQ-1);
      issue_id_q    <= '0;
      issue_v_q     <= 1'b0;
      rom_address_q <= '0;
      rvalid_q      <= '0;
      rdata_q       <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      issue_id_q    <= issue_id_d;
      issue_v_q     <= issue_v_d;
      rom_address_q <= rom_address_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
    end
  end

  assign bus.gnt     = gnt_vec;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign rom_address = rom_address_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter (N_REQ=4, ADDR_W=10, DATA_W=4).
// The ROM model returns addr[3:0]. Each expected grant pushes the expected
// read return onto a scoreboard; a monitor pops it when it falls due and
// requires rvalid=0 in every other cycle.
module tb_sprite_rom_arbiter;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       blank   = 1'b0;
  logic [9:0] rom_address;
  logic [3:0] rom_q;
  logic [9:0] a [4];

  sprite_rom_if #(.N_REQ(4), .ADDR_W(10), .DATA_W(4)) bus ();

  sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(10), .DATA_W(4)) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .blank       (blank),
    .bus         (bus),
    .rom_address (rom_address),
    .rom_q       (rom_q)
  );

  always #5 vga_clk = ~vga_clk;

  always @(negedge vga_clk) rom_q <= rom_address[3:0];

  assign bus.req_addr = {a[3], a[2], a[1], a[0]};

  typedef struct { int id; logic [3:0] data; int due; } exp_t;
  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Return-path monitor
  always @(posedge vga_clk) begin
    exp_t e;
    cyc = cyc + 1;
    #1;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("rvalid", {28'd0, bus.rvalid}, 32'd1 << e.id);
      chk("rdata", {28'd0, bus.rdata}, {28'd0, e.data});
    end else begin
      chk("rvalid_idle", {28'd0, bus.rvalid}, 32'd0);
    end
  end

  // One request cycle: drive, check the combinational grant, book the return.
  task automatic step(input logic b, input logic [3:0] r, input logic [3:0] eg);
    int id;
    id = -1;
    blank   = b;
    bus.req = r;
    #1;
    chk("gnt", {28'd0, bus.gnt}, {28'd0, eg});
    for (int i = 0; i < 4; i++) if (eg[i]) id = i;
    if (id >= 0) sb.push_back('{id: id, data: a[id][3:0], due: cyc + 2});
    @(posedge vga_clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) a[i] = 10'(16 * i + i + 1);
    bus.req = 4'b1111;
    @(posedge vga_clk);
    #2;

    // reset with all requests pending
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1111, 4'b0000);
    chk("rst_rdata", {28'd0, bus.rdata}, 32'd0);
    chk("rst_rom_address", {22'd0, rom_address}, 32'd0);

    // release: requester 0 first, then round-robin over all four
    reset_n = 1'b1;
    step(1'b0, 4'b1111, 4'b0001);
    for (int i = 1; i < 8; i++) step(1'b0, 4'b1111, 4'(1 << (i % 4)));
    step(1'b0, 4'b0000, 4'b0000);
    step(1'b0, 4'b0000, 4'b0000);

    // single-read latency
    a[2] = 10'd37;
    step(1'b0, 4'b0100, 4'b0100);
    chk("lat_rom_address", {22'd0, rom_address}, 32'd37);
    step(1'b0, 4'b0000, 4'b0000);
    step(1'b0, 4'b0000, 4'b0000);

    // park the pointer on 0, then strict priority during active video
    step(1'b0, 4'b0001, 4'b0001);
    for (int i = 0; i < 4; i++) step(1'b1, 4'b1011, 4'b0001);
    step(1'b0, 4'b1011, 4'b0010);
    step(1'b0, 4'b1011, 4'b1000);
    step(1'b0, 4'b1011, 4'b0001);

    // pixel path held high blocks everyone during active video
    for (int i = 0; i < 6; i++) step(1'b1, 4'b1111, 4'b0001);
    step(1'b0, 4'b0000, 4'b0000);
    step(1'b0, 4'b0000, 4'b0000);

    // reset while a read for requester 3 is in flight
    step(1'b0, 4'b1000, 4'b1000);
    reset_n = 1'b0;
    sb.delete();
    step(1'b0, 4'b1111, 4'b0000);
    reset_n = 1'b1;
    step(1'b0, 4'b1111, 4'b0001);
    step(1'b0, 4'b0000, 4'b0000);

    // back-to-back reads from requester 1, address advancing per grant
    for (int i = 0; i < 5; i++) begin
      a[1] = 10'(i);
      step(1'b0, 4'b0010, 4'b0010);
    end

    // drain, bounded
    for (int i = 0; i < 6 && sb.size() > 0; i++) step(1'b0, 4'b0000, 4'b0000);
    chk("drain_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
